// File: rtl/intctl.sv
// intctl: interrupt controller sitting in front of the register file and
// the fetch unit.
//
// Rising edges on the request lines are latched as pending. At an
// instruction boundary (fetch) with interrupts enabled, the lowest-index
// pending request is taken: a one-cycle take pulse redirects fetch to
// `vector`, and `intRA` holds the return address. No further request is
// taken until iret.
//
// Optional feature: define INTCTL_MASK_EN to add a per-line mask register
// (ports mask_we / mask_d / mask). Masked lines still latch pending but
// are not taken until unmasked.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   irq        - request lines (level), edge-detected internally
//   pc         - address of the next instruction
//   fetch      - one-cycle pulse at each instruction boundary
//   ien_set    - enable interrupts (clear wins if both)
//   ien_clr    - disable interrupts
//   iret       - return from interrupt (only honoured while active)
//   ienabled   - global interrupt enable
//   istatus    - high while a handler is active
//   intRA      - return address captured at the last boundary
//   take       - one-cycle pulse, fetch loads `vector`
//   vector     - handler address for the selected line
//   ipend      - latched pending requests
//   mask_we, mask_d, mask - line mask (INTCTL_MASK_EN only)
module intctl #(
  parameter int          NIRQ     = 4,
  parameter logic [15:0] VEC_BASE = 16'hFF00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic [15:0]     pc,
  input  logic            fetch,
  input  logic            ien_set,
  input  logic            ien_clr,
  input  logic            iret,
`ifdef INTCTL_MASK_EN
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_d,
  output logic [NIRQ-1:0] mask,
`endif
  output logic            ienabled,
  output logic            istatus,
  output logic [15:0]     intRA,
  output logic            take,
  output logic [15:0]     vector,
  output logic [NIRQ-1:0] ipend
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ENTER  = 2'b01,
    ACTIVE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [NIRQ-1:0] irq_sync;
  logic [NIRQ-1:0] irq_prev;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] ipend_eff;
  logic [NIRQ-1:0] clr_bits;
  logic [2:0]      sel;
  logic [2:0]      sel_q;
  logic            start;

  // Request lines are registered once before edge detection, so a rise
  // first seen at one edge becomes pending on the following edge.
  assign rise = irq_sync & ~irq_prev;

`ifdef INTCTL_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '1;
    end else if (mask_we) begin
      mask <= mask_d;
    end
  end

  assign ipend_eff = ipend & mask;
`else
  assign ipend_eff = ipend;
`endif

  // Lowest index wins: scan downwards so the last hit is the lowest set bit.
  always_comb begin
    sel = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (ipend_eff[i]) begin
        sel = 3'(i);
      end
    end
  end

  assign start = (state == IDLE) && fetch && ienabled && (|ipend_eff);

  // During ENTER the line captured at the boundary is retired.
  always_comb begin
    clr_bits = '0;
    if (state == ENTER) begin
      for (int i = 0; i < NIRQ; i++) begin
        if (3'(i) == sel_q) begin
          clr_bits[i] = 1'b1;
        end
      end
    end
  end

  // Edge detector and pending latch; a new rise beats a same-cycle clear.
  // History resets to all ones so lines already high at reset never pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_sync <= '1;
      irq_prev <= '1;
      ipend    <= '0;
    end else begin
      irq_sync <= irq;
      irq_prev <= irq_sync;
      ipend    <= (ipend & ~clr_bits) | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ienabled <= 1'b0;
    end else if (ien_clr) begin
      ienabled <= 1'b0;
    end else if (ien_set) begin
      ienabled <= 1'b1;
    end
  end

  // The return address tracks every boundary outside a handler, so it
  // already holds the interrupted pc when the take starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      intRA <= 16'h0000;
    end else if (fetch && !istatus) begin
      intRA <= pc;
    end
  end

  // Vector is computed once at the boundary and held for the take pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      vector <= VEC_BASE;
    end else if (start) begin
      sel_q  <= sel;
      vector <= VEC_BASE + {9'd0, sel, 4'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ENTER;
      ENTER:   state_next = ACTIVE;
      ACTIVE:  if (iret) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    take    = 1'b0;
    istatus = 1'b0;
    case (state)
      ENTER:   take    = 1'b1;
      ACTIVE:  istatus = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intctl.sv
// tb_intctl: self-checking bench for intctl (NIRQ = 4, VEC_BASE = FF00).
// A directed vector table walks the main scenarios, hand-written rows cover
// set-wins-over-clear during ENTER, reset during ENTER and (when
// INTCTL_MASK_EN is defined) the mask, then random stimulus is compared
// against a behavioural reference model.
module tb_intctl;

  localparam int          NIRQ     = 4;
  localparam logic [15:0] VEC_BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic [15:0] pc;
  logic        fetch;
  logic        ien_set;
  logic        ien_clr;
  logic        iret;
  logic        ienabled;
  logic        istatus;
  logic [15:0] intRA;
  logic        take;
  logic [15:0] vector;
  logic [3:0]  ipend;
`ifdef INTCTL_MASK_EN
  logic        mask_we;
  logic [3:0]  mask_d;
  logic [3:0]  mask;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        fetch;
    logic        ien_set;
    logic        ien_clr;
    logic        iret;
    logic [15:0] pc;
    logic        exp_take;
    logic        exp_istatus;
    logic        exp_ien;
    logic [3:0]  exp_ipend;
    logic [15:0] exp_vector;
    logic [15:0] exp_intra;
  } vec_t;

  // Reference model state
  logic [3:0]  mIrqD1;
  logic [3:0]  mIrqD2;
  logic [3:0]  mPend;
  logic [3:0]  mMask;
  logic        mIen;
  logic [15:0] mIntRA;
  logic [15:0] mVector;
  int          mPhase;
  int          mSel;

  intctl #(.NIRQ(NIRQ), .VEC_BASE(VEC_BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .pc       (pc),
    .fetch    (fetch),
    .ien_set  (ien_set),
    .ien_clr  (ien_clr),
    .iret     (iret),
`ifdef INTCTL_MASK_EN
    .mask_we  (mask_we),
    .mask_d   (mask_d),
    .mask     (mask),
`endif
    .ienabled (ienabled),
    .istatus  (istatus),
    .intRA    (intRA),
    .take     (take),
    .vector   (vector),
    .ipend    (ipend)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] i, input logic f,
                              input logic s, input logic c, input logic ir,
                              input logic [15:0] p, input logic et, input logic es,
                              input logic ee, input logic [3:0] ep,
                              input logic [15:0] ev, input logic [15:0] ea);
    vec_t v;
    v.rst = r; v.irq = i; v.fetch = f; v.ien_set = s; v.ien_clr = c; v.iret = ir;
    v.pc = p; v.exp_take = et; v.exp_istatus = es; v.exp_ien = ee;
    v.exp_ipend = ep; v.exp_vector = ev; v.exp_intra = ea;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the clock edge.
  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    irq     = v.irq;
    fetch   = v.fetch;
    ien_set = v.ien_set;
    ien_clr = v.ien_clr;
    iret    = v.iret;
    pc      = v.pc;
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput({tag, " take"},     16'(take),     16'(v.exp_take));
    checkOutput({tag, " istatus"},  16'(istatus),  16'(v.exp_istatus));
    checkOutput({tag, " ienabled"}, 16'(ienabled), 16'(v.exp_ien));
    checkOutput({tag, " ipend"},    16'(ipend),    16'(v.exp_ipend));
    checkOutput({tag, " vector"},   vector,        v.exp_vector);
    checkOutput({tag, " intRA"},    intRA,         v.exp_intra);
  endtask

  function automatic int lowestSet(input logic [3:0] bits);
    for (int i = 0; i < 4; i++) begin
      if (bits[i]) return i;
    end
    return 0;
  endfunction

  // Behavioural model: phase 0 = no interrupt in progress, 1 = take cycle,
  // 2 = handler running. Advanced once per clock from the driven inputs.
  task automatic modelStep();
    logic [3:0] riseBits;
    logic [3:0] clrBits;
    logic [3:0] eligible;
    if (rst) begin
      mIrqD1 = 4'hF; mIrqD2 = 4'hF; mPend = 4'h0; mMask = 4'hF;
      mIen = 1'b0; mIntRA = 16'h0; mVector = VEC_BASE; mPhase = 0; mSel = 0;
      return;
    end
    riseBits = mIrqD1 & ~mIrqD2;
    clrBits  = (mPhase == 1) ? 4'(1 << mSel) : 4'h0;
    eligible = mPend & mMask;
    if (fetch && mPhase != 2) mIntRA = pc;
    if (mPhase == 0) begin
      if (fetch && mIen && eligible != 4'h0) begin
        mSel    = lowestSet(eligible);
        mVector = VEC_BASE + 16'(16 * mSel);
        mPhase  = 1;
      end
    end else if (mPhase == 1) begin
      mPhase = 2;
    end else if (iret) begin
      mPhase = 0;
    end
    mPend = (mPend & ~clrBits) | riseBits;
    if (ien_clr) mIen = 1'b0;
    else if (ien_set) mIen = 1'b1;
`ifdef INTCTL_MASK_EN
    if (mask_we) mMask = mask_d;
`endif
    mIrqD2 = mIrqD1;
    mIrqD1 = irq;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; irq = 4'h0; pc = 16'h0; fetch = 1'b0;
    ien_set = 1'b0; ien_clr = 1'b0; iret = 1'b0;
`ifdef INTCTL_MASK_EN
    mask_we = 1'b0; mask_d = 4'hF;
`endif
    mIrqD1 = 4'hF; mIrqD2 = 4'hF; mPend = 4'h0; mMask = 4'hF; mIen = 1'b0;
    mIntRA = 16'h0; mVector = VEC_BASE; mPhase = 0; mSel = 0;

    //        rst irq    f  set clr iret pc        take ist ien ipend   vector    intRA
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'hFF00, 16'h0000));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'hFF00, 16'h0000));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'hFF00, 16'h0000));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 16'h1111, 0, 0, 0, 4'b0001, 16'hFF00, 16'h1111));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 16'h2222, 0, 0, 0, 4'b0001, 16'hFF00, 16'h2222));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 4'b0001, 16'hFF00, 16'h2222));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 16'h1234, 1, 0, 1, 4'b0001, 16'hFF00, 16'h1234));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4'b0000, 16'hFF00, 16'h1234));
    tbl.push_back(mk(0, 4'b1011, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4'b0000, 16'hFF00, 16'h1234));
    tbl.push_back(mk(0, 4'b1011, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4'b1010, 16'hFF00, 16'h1234));
    tbl.push_back(mk(0, 4'b1011, 1, 0, 0, 0, 16'h5555, 0, 1, 1, 4'b1010, 16'hFF00, 16'h1234));
    tbl.push_back(mk(0, 4'b1011, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 4'b1010, 16'hFF00, 16'h1234));
    tbl.push_back(mk(0, 4'b1011, 1, 0, 0, 0, 16'h3000, 1, 0, 1, 4'b1010, 16'hFF10, 16'h3000));
    tbl.push_back(mk(0, 4'b1011, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4'b1000, 16'hFF10, 16'h3000));
    tbl.push_back(mk(0, 4'b1011, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 4'b1000, 16'hFF10, 16'h3000));
    tbl.push_back(mk(0, 4'b1011, 1, 0, 0, 0, 16'h3100, 1, 0, 1, 4'b1000, 16'hFF30, 16'h3100));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4'b0000, 16'hFF30, 16'h3100));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 16'h4000, 0, 1, 1, 4'b0100, 16'hFF30, 16'h3100));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 16'h4100, 0, 1, 1, 4'b0100, 16'hFF30, 16'h3100));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 4'b0100, 16'hFF30, 16'h3100));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 16'h4200, 1, 0, 1, 4'b0100, 16'hFF20, 16'h4200));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4'b0000, 16'hFF20, 16'h4200));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 1, 0, 16'h0000, 0, 1, 0, 4'b0000, 16'hFF20, 16'h4200));
    tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 4'b0000, 16'hFF20, 16'h4200));

    foreach (tbl[i]) runVec(tbl[i], $sformatf("tbl%0d", i));

    // Bit 0 re-rises exactly on the ENTER edge: set beats clear, so it is
    // taken again after iret. Then reset lands in ENTER; a line already
    // high across reset must not pend afterwards.
    runVec(mk(0, 4'b0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'hFF20, 16'h4200), "seq1");
    runVec(mk(0, 4'b0001, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 4'b0000, 16'hFF20, 16'h4200), "seq2");
    runVec(mk(0, 4'b0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 4'b0001, 16'hFF20, 16'h4200), "seq3");
    runVec(mk(0, 4'b0001, 1, 0, 0, 0, 16'h6000, 1, 0, 1, 4'b0001, 16'hFF00, 16'h6000), "seq4");
    runVec(mk(0, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4'b0001, 16'hFF00, 16'h6000), "seq5");
    runVec(mk(0, 4'b0001, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 4'b0001, 16'hFF00, 16'h6000), "seq6");
    runVec(mk(0, 4'b0001, 1, 0, 0, 0, 16'h6100, 1, 0, 1, 4'b0001, 16'hFF00, 16'h6100), "seq7");
    runVec(mk(1, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'hFF00, 16'h0000), "seq8");
    runVec(mk(0, 4'b0001, 1, 0, 0, 0, 16'h7000, 0, 0, 0, 4'b0000, 16'hFF00, 16'h7000), "seq9");
    runVec(mk(0, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'hFF00, 16'h7000), "seq10");

`ifdef INTCTL_MASK_EN
    // Masked line pends but is not taken until the mask is reopened.
    mask_we = 1'b1; mask_d = 4'b1110;
    runVec(mk(0, 4'b0000, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 4'b0000, 16'hFF00, 16'h7000), "msk1");
    checkOutput("msk1 mask", 16'(mask), 16'(4'b1110));
    mask_we = 1'b0;
    runVec(mk(0, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 4'b0000, 16'hFF00, 16'h7000), "msk2");
    runVec(mk(0, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 4'b0001, 16'hFF00, 16'h7000), "msk3");
    runVec(mk(0, 4'b0001, 1, 0, 0, 0, 16'h8000, 0, 0, 1, 4'b0001, 16'hFF00, 16'h8000), "msk4");
    mask_we = 1'b1; mask_d = 4'b1111;
    runVec(mk(0, 4'b0001, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 4'b0001, 16'hFF00, 16'h8000), "msk5");
    mask_we = 1'b0;
    runVec(mk(0, 4'b0001, 1, 0, 0, 0, 16'h8100, 1, 0, 1, 4'b0001, 16'hFF00, 16'h8100), "msk6");
`endif

    // Random phase against the behavioural model.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] flip;
      flip = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
      end
      rst     = (i < 2) || ($urandom_range(0, 199) == 0);
      irq     = irq ^ flip;
      fetch   = ($urandom_range(0, 2) == 0);
      ien_set = ($urandom_range(0, 7) == 0);
      ien_clr = ($urandom_range(0, 24) == 0);
      iret    = ($urandom_range(0, 9) == 0);
      pc      = 16'($urandom);
`ifdef INTCTL_MASK_EN
      mask_we = ($urandom_range(0, 19) == 0);
      mask_d  = 4'($urandom);
`endif
      @(posedge clk);
      #1;
      modelStep();
      checkOutput($sformatf("rnd%0d take", i),     16'(take),     16'(mPhase == 1));
      checkOutput($sformatf("rnd%0d istatus", i),  16'(istatus),  16'(mPhase == 2));
      checkOutput($sformatf("rnd%0d ienabled", i), 16'(ienabled), 16'(mIen));
      checkOutput($sformatf("rnd%0d ipend", i),    16'(ipend),    16'(mPend));
      checkOutput($sformatf("rnd%0d vector", i),   vector,        mVector);
      checkOutput($sformatf("rnd%0d intRA", i),    intRA,         mIntRA);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intctl.md
# intctl

Interrupt controller that sits directly upstream of the register file. It supplies `istatus`, `ienabled` and `intRA`, and the register file uses them to bank DX/DY into the interrupt-return copies. It also supplies `take` and `vector`, which redirect the fetch unit. Rising edges on the request lines are latched as pending, the highest-priority request is taken at an instruction boundary, and all other requests are held off until `iret`.

## Interface
Parameters:
- `NIRQ`, default 4: number of request lines; legal range 1..8.
- `VEC_BASE`, default 16'hFF00: vector address for line 0.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `irq` in NIRQ: request lines, level inputs, edge-detected internally.
- `pc` in 16: address of the next instruction.
- `fetch` in 1: high for one cycle at each instruction boundary.
- `ien_set` in 1: decoded "enable interrupts" instruction.
- `ien_clr` in 1: decoded "disable interrupts" instruction.
- `iret` in 1: decoded "return from interrupt" instruction.
- `ienabled` out 1: global interrupt enable.
- `istatus` out 1: high while a handler is active.
- `intRA` out 16: return address captured at the last boundary.
- `take` out 1: one-cycle pulse; the core loads `vector` into PC instead of the sequential address.
- `vector` out 16: handler address for the selected line.
- `ipend` out NIRQ: latched pending requests.

## Operation
- Edge detect: `irq_prev` is registered every cycle. A pending bit `ipend[i]` is set when `irq[i] & ~irq_prev[i]`.
- Pending bits are cleared only by a take.
- If a bit is set and cleared in the same cycle, the set wins.
- Priority: the lowest-index pending bit (after masking) is selected as `sel`.
- `vector` is registered: `vector = VEC_BASE + 16*sel`, modulo 2^16.
- `ienabled`:
  - set by `ien_set`, cleared by `ien_clr`;
  - if both are asserted in the same cycle, clear wins;
  - it is not changed by take or `iret`.
- `intRA` loads `pc` on every cycle with `fetch & ~istatus`. It holds otherwise.
- State machine, encoded so that `istatus` is high only in ACTIVE:
  - **IDLE**: on `fetch & ienabled & |ipend_eff`, capture `sel`, load `intRA <= pc`, and go to ENTER.
  - **ENTER**: assert `take` for this cycle only and clear `ipend[sel]`. The register file latches `intRA` into IRX/IRY at the end of this cycle. Go to ACTIVE unconditionally.
  - **ACTIVE**: no new take; pending bits keep accumulating. On `iret`, go to IDLE.
- `iret` outside ACTIVE is ignored.
- No nesting: a second interrupt can only be taken after `iret`.

## Timing
- Reset values:
  - state IDLE;
  - `ienabled` 0, `istatus` 0, `take` 0;
  - `intRA` 16'h0000, `vector` VEC_BASE, `ipend` 0;
  - `irq_prev` all ones, so lines already high at reset do not pend.
- `rst` asserted in any state, including ENTER, returns all of the above values on the next edge.
- Edge-to-pending latency: an `irq` rising edge sampled at edge k gives `ipend` high after edge k+1.
- Boundary to take:
  - cycle N has `fetch` high in IDLE with a request pending;
  - cycle N+1 has `take` = 1 with `vector` valid and `istatus` = 0;
  - `istatus` = 1 from N+2.
- `iret` asserted in cycle M gives `istatus` = 0 from M+1. The earliest next take is at the following boundary after M+1.
- A pending bit that rises during ENTER is kept. It is not lost or taken twice.
- A `fetch` with `ienabled` = 0 takes nothing; pending bits are retained.

## Configuration
- Macro `INTCTL_MASK_EN`.
- Defined:
  - adds ports `mask_we` in 1, `mask_d` in NIRQ and `mask` out NIRQ;
  - `mask` loads `mask_d` when `mask_we` is high and resets to all ones;
  - `ipend_eff = ipend & mask`;
  - masked lines still latch pending and are taken once unmasked.
- Undefined: no mask ports or register, and `ipend_eff = ipend`.

## Test plan
- Reset, then raise `irq` = 4'b0001 with `ienabled` = 0 and pulse `fetch` -> `ipend` = 4'b0001, `take` never asserts, `istatus` stays 0.
- `ien_set`, then `fetch` with `pc` = 16'h1234 -> `take` = 1 for exactly one cycle with `vector` = 16'hFF00 and `intRA` = 16'h1234, `istatus` = 1 one cycle later, `ipend` = 0.
- Raise `irq[3]` and `irq[1]` in the same cycle, take -> `vector` = 16'hFF10, `ipend` = 4'b1000. After `iret` and the next `fetch`, the second take gives `vector` = 16'hFF30.
- While ACTIVE, raise `irq[2]` and pulse `fetch` repeatedly -> no `take` and `intRA` unchanged. After `iret`, the next `fetch` gives `take` with `vector` = 16'hFF20.
- `ien_set` and `ien_clr` in the same cycle -> `ienabled` = 0. Assert `rst` during ENTER -> `istatus` 0, `take` 0, `ipend` 0, state IDLE on the next cycle.
- With `INTCTL_MASK_EN` defined: write `mask` = 4'b1110 and raise `irq[0]` -> no take. Then write `mask` = 4'b1111 -> take with `vector` = 16'hFF00 at the next `fetch`.
